hazard_unit: RTL and testbench

Central hazard controller for the 5-stage pipeline. It generates the select codes for the EX-stage operand forwarding muxes and the 1-bit ID-stage branch-compare forwarding selects. It also produces stall, freeze and flush controls for load-use, branch-operand, HI/LO (mult/div) and memory-wait hazards. Multi-cycle mult/div occupancy is tracked by an internal busy FSM/counter, and a saturating stall-cycle performance counter is maintained.

---
 rtl/hazard_unit_pkg.sv | 28 ++
 rtl/hazard_unit_md_busy_tracker.sv | 38 +++
 rtl/hazard_unit.sv | 126 ++++++++++++
 tb/tb_hazard_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared constants, encodings and helpers for the pipeline hazard controller.
package hazard_unit_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned MD_CNT_W        = 6;
  localparam int unsigned STALL_CNT_W     = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

  typedef enum logic [1:0] {
    NOT_FORWARD = 2'b00,
    FORWARD_MEM = 2'b01,
    FORWARD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A stage produces a source operand only if it writes a non-zero matching register.
  function automatic logic reg_match(input logic             we,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
    return we && (rd != REG_W'(0)) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_unit_md_busy_tracker.sv
// Tracks mult/div unit occupancy; the latest accepted operation reloads the count.
module hazard_unit_md_busy_tracker
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic md_busy_o
);

  md_state_e             state_q;
  logic [MD_CNT_W-1:0]   count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else if (start_i) begin
      state_q <= MD_BUSY;
      count_q <= div_i ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    end else if (state_q == MD_BUSY) begin
      // The cycle holding count 1 is the last busy cycle.
      if (count_q <= MD_CNT_W'(1)) begin
        state_q <= MD_IDLE;
        count_q <= '0;
      end else begin
        count_q <= count_q - MD_CNT_W'(1);
      end
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Central hazard controller: forwarding selects, stall/flush generation, mult/div
// occupancy and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_branch,
  input  logic                   id_md_read,
  input  logic                   id_md_start,
  input  logic [REG_W-1:0]       ex_rs,
  input  logic [REG_W-1:0]       ex_rt,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic                   ex_md_start,
  input  logic                   ex_md_div,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_read,
  input  logic [REG_W-1:0]       mem_rd,
  input  logic                   wb_reg_write,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic                   mem_wait,
  output logic [1:0]             fwd_a_ex,
  output logic [1:0]             fwd_b_ex,
  output logic                   fwd_a_id,
  output logic                   fwd_b_id,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   flush_ex,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic mem_hit_ex_rs, mem_hit_ex_rt, wb_hit_ex_rs, wb_hit_ex_rt;
  logic mem_hit_id_rs, mem_hit_id_rt, ex_hit_id_rs, ex_hit_id_rt;
  logic ex_used, mem_used;
  logic load_use, br_ex, br_ld, md_haz, hz;
  logic md_accept;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  assign mem_hit_ex_rs = reg_match(mem_reg_write, mem_rd, ex_rs);
  assign mem_hit_ex_rt = reg_match(mem_reg_write, mem_rd, ex_rt);
  assign wb_hit_ex_rs  = reg_match(wb_reg_write, wb_rd, ex_rs);
  assign wb_hit_ex_rt  = reg_match(wb_reg_write, wb_rd, ex_rt);
  assign mem_hit_id_rs = reg_match(mem_reg_write, mem_rd, id_rs);
  assign mem_hit_id_rt = reg_match(mem_reg_write, mem_rd, id_rt);
  assign ex_hit_id_rs  = reg_match(ex_reg_write, ex_rd, id_rs);
  assign ex_hit_id_rt  = reg_match(ex_reg_write, ex_rd, id_rt);

  // EX operand selects: the younger MEM result wins over WB.
  always_comb begin
    fwd_a_ex = NOT_FORWARD;
    fwd_b_ex = NOT_FORWARD;
    if (mem_hit_ex_rs)     fwd_a_ex = FORWARD_MEM;
    else if (wb_hit_ex_rs) fwd_a_ex = FORWARD_WB;
    if (mem_hit_ex_rt)     fwd_b_ex = FORWARD_MEM;
    else if (wb_hit_ex_rt) fwd_b_ex = FORWARD_WB;
  end

  // A load in MEM has no data yet, so it never feeds the branch comparator.
  assign fwd_a_id = mem_hit_id_rs && !mem_mem_read;
  assign fwd_b_id = mem_hit_id_rt && !mem_mem_read;

  assign ex_used  = (id_uses_rs && ex_hit_id_rs)  || (id_uses_rt && ex_hit_id_rt);
  assign mem_used = (id_uses_rs && mem_hit_id_rs) || (id_uses_rt && mem_hit_id_rt);

  assign load_use = ex_mem_read && ex_used;
  assign br_ex    = id_branch && ex_used;
  assign br_ld    = id_branch && mem_mem_read && mem_used;
  assign md_haz   = (id_md_read || id_md_start) && (md_busy || ex_md_start);
  assign hz       = load_use || br_ex || br_ld || md_haz;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_ex  = 1'b0;
    if (mem_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (hz) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_ex  = 1'b1;
    end
  end

  assign md_accept = ex_md_start && !stall_ex;

  hazard_unit_md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk       (clk),
    .reset     (reset),
    .start_i   (md_accept),
    .div_i     (ex_md_div),
    .md_busy_o (md_busy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_if && (stall_count_q != '1)) stall_count_d = stall_count_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized cycles
// compared against a cycle-indexed behavioural model.
module tb_hazard_unit;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 32;

  logic       clk, reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_branch, id_md_read, id_md_start;
  logic       ex_reg_write, ex_mem_read, ex_md_start, ex_md_div;
  logic       mem_reg_write, mem_mem_read, wb_reg_write, mem_wait;
  logic [1:0] fwd_a_ex, fwd_b_ex;
  logic       fwd_a_id, fwd_b_id, stall_if, stall_id, stall_ex, stall_mem, flush_ex, md_busy;
  logic [31:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state: current cycle index, last cycle the MD unit is busy, stall cycles seen.
  longint cyc, busy_end, scnt;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        ia, ib, sif, sid, sex, smem, fl, busy;
    logic [31:0] cnt;
  } exp_t;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_md_read(id_md_read), .id_md_start(id_md_start),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .mem_wait(mem_wait),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_ex(flush_ex), .md_busy(md_busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic prod(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic logic [1:0] m_fwd_ex(input logic [4:0] src);
    if (prod(mem_reg_write, mem_rd, src)) return 2'd1;
    if (prod(wb_reg_write, wb_rd, src))   return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic busy, used_ex, used_mem, hz;
    busy     = !reset && (cyc <= busy_end);
    e.fa     = m_fwd_ex(ex_rs);
    e.fb     = m_fwd_ex(ex_rt);
    e.ia     = prod(mem_reg_write, mem_rd, id_rs) && !mem_mem_read;
    e.ib     = prod(mem_reg_write, mem_rd, id_rt) && !mem_mem_read;
    used_ex  = (id_uses_rs && prod(ex_reg_write, ex_rd, id_rs)) ||
               (id_uses_rt && prod(ex_reg_write, ex_rd, id_rt));
    used_mem = (id_uses_rs && prod(mem_reg_write, mem_rd, id_rs)) ||
               (id_uses_rt && prod(mem_reg_write, mem_rd, id_rt));
    hz = (ex_mem_read && used_ex) || (id_branch && used_ex) ||
         (id_branch && mem_mem_read && used_mem) ||
         ((id_md_read || id_md_start) && (busy || ex_md_start));
    e.sif  = mem_wait || hz;
    e.sid  = mem_wait || hz;
    e.sex  = mem_wait;
    e.smem = mem_wait;
    e.fl   = !mem_wait && hz;
    e.busy = busy;
    e.cnt  = scnt[31:0];
    return e;
  endfunction

  // Advance the model by the current cycle's inputs, then move to the next negedge.
  task automatic tick();
    exp_t e;
    e = model();
    if (reset) begin
      busy_end = -1;
      scnt     = 0;
    end else begin
      if (e.sif && scnt < 64'hFFFF_FFFF) scnt = scnt + 1;
      if (ex_md_start && !mem_wait) busy_end = cyc + (ex_md_div ? DIV_C : MULT_C);
    end
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs, id_uses_rt, id_branch, id_md_read, id_md_start} = '0;
    {ex_reg_write, ex_mem_read, ex_md_start, ex_md_div} = '0;
    {mem_reg_write, mem_mem_read, wb_reg_write, mem_wait} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    cyc = 0; busy_end = -1; scnt = 0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    n_vec++;
    if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_stall_count: got %0h want 0", stall_count); end
    n_vec++;
    if (stall_if !== 1'b0) begin n_err++; $display("FAIL reset_stall_if: got %b want 0", stall_if); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forward();
    clear_inputs();
    mem_rd = 5'd8; wb_rd = 5'd8; ex_rs = 5'd8; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    #1; n_vec++;
    if (fwd_a_ex !== 2'b01) begin n_err++; $display("FAIL fwd_mem_prio: got %b want 01", fwd_a_ex); end
    mem_reg_write = 1'b0;
    #1; n_vec++;
    if (fwd_a_ex !== 2'b10) begin n_err++; $display("FAIL fwd_wb: got %b want 10", fwd_a_ex); end
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0;
    #1; n_vec++;
    if (fwd_a_ex !== 2'b00) begin n_err++; $display("FAIL fwd_r0: got %b want 00", fwd_a_ex); end
    mem_rd = 5'd8; ex_rt = 5'd8; id_rt = 5'd8;
    #1; n_vec++;
    if ({fwd_b_ex, fwd_b_id} !== 3'b011) begin n_err++; $display("FAIL fwd_b_alu: got %b want 011", {fwd_b_ex, fwd_b_id}); end
    mem_mem_read = 1'b1;
    #1; n_vec++;
    if (fwd_b_id !== 1'b0) begin n_err++; $display("FAIL fwd_id_load: got %b want 0", fwd_b_id); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    clear_inputs();
    c0 = scnt[31:0];
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1; n_vec++;
    if ({stall_if, stall_id, flush_ex, stall_ex, stall_mem} !== 5'b11100) begin
      n_err++; $display("FAIL load_use_stall: got %b want 11100", {stall_if, stall_id, flush_ex, stall_ex, stall_mem});
    end
    tick();
    // Load advances to MEM, a bubble sits in EX: no further stall.
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9;
    #1; n_vec++;
    if (stall_if !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %b want 0", stall_if); end
    n_vec++;
    if (stall_count !== c0 + 32'd1) begin n_err++; $display("FAIL load_use_count: got %0h want %0h", stall_count, c0 + 32'd1); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    logic [31:0] c0;
    clear_inputs();
    c0 = scnt[31:0];
    id_branch = 1'b1; id_rs = 5'd10; id_uses_rs = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd10;
    #1; n_vec++;
    if ({stall_if, flush_ex} !== 2'b11) begin n_err++; $display("FAIL br_ex: got %b want 11", {stall_if, flush_ex}); end
    tick();
    {ex_mem_read, ex_reg_write, ex_rd} = '0;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd10;
    #1; n_vec++;
    if ({stall_if, flush_ex, fwd_a_id} !== 3'b110) begin n_err++; $display("FAIL br_ld: got %b want 110", {stall_if, flush_ex, fwd_a_id}); end
    tick();
    mem_mem_read = 1'b0;
    #1; n_vec++;
    if ({stall_if, fwd_a_id} !== 2'b01) begin n_err++; $display("FAIL br_fwd_alu: got %b want 01", {stall_if, fwd_a_id}); end
    n_vec++;
    if (stall_count !== c0 + 32'd2) begin n_err++; $display("FAIL br_count: got %0h want %0h", stall_count, c0 + 32'd2); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_md(input logic is_div);
    int n;
    n = is_div ? DIV_C : MULT_C;
    clear_inputs();
    ex_md_start = 1'b1; ex_md_div = is_div; id_md_read = 1'b1;
    #1; n_vec++;
    if ({md_busy, stall_if} !== 2'b01) begin n_err++; $display("FAIL md_start_c0: got %b want 01", {md_busy, stall_if}); end
    tick();
    ex_md_start = 1'b0; ex_md_div = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      #1; n_vec++;
      if ({md_busy, stall_if} !== {2{k <= n}}) begin
        n_err++; $display("FAIL md_cycle%0d div=%b: got %b want %b", k, is_div, {md_busy, stall_if}, {2{k <= n}});
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    mem_wait = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    ex_md_start = 1'b1; ex_md_div = 1'b1;
    #1; n_vec++;
    if ({stall_if, stall_id, stall_ex, stall_mem, flush_ex} !== 5'b11110) begin
      n_err++; $display("FAIL mem_wait_stalls: got %b want 11110", {stall_if, stall_id, stall_ex, stall_mem, flush_ex});
    end
    tick();
    clear_inputs();
    #1; n_vec++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mem_wait_no_accept: got %b want 0", md_busy); end
    tick();
  endtask

  task automatic test_random();
    exp_t e, got;
    for (int i = 0; i < 400; i++) begin
      {id_rs, id_rt, ex_rs, ex_rt} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {ex_rd, mem_rd, wb_rd} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {id_uses_rs, id_uses_rt, id_branch} = 3'($urandom);
      {ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write} = 5'($urandom);
      id_md_read  = ($urandom_range(0, 3) == 0);
      id_md_start = ($urandom_range(0, 7) == 0);
      ex_md_start = ($urandom_range(0, 15) == 0);
      ex_md_div   = 1'($urandom);
      mem_wait    = ($urandom_range(0, 7) == 0);
      #1;
      e   = model();
      got = {fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall_if, stall_id, stall_ex, stall_mem,
             flush_ex, md_busy, stall_count};
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL random_cycle%0d: got %h want %h", i, got, e); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_saturate();
    clear_inputs();
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    scnt = 64'hFFFF_FFFE;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    #1; n_vec++;
    if (stall_count !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %h want fffffffe", stall_count); end
    tick();
    #1; n_vec++;
    if (stall_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_reach: got %h want ffffffff", stall_count); end
    tick();
    #1; n_vec++;
    if (stall_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffffffff", stall_count); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    ex_md_start = 1'b1; ex_md_div = 1'b1;
    tick();
    clear_inputs();
    repeat (15) tick();
    // The divide now holds count 17.
    #1; n_vec++;
    if (md_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", md_busy); end
    reset = 1'b1;
    #1; n_vec++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", md_busy); end
    n_vec++;
    if (stall_count !== 32'd0) begin n_err++; $display("FAIL mid_reset_count: got %h want 0", stall_count); end
    tick();
    reset = 1'b0;
    id_md_read = 1'b1;
    #1; n_vec++;
    if ({md_busy, stall_if} !== 2'b00) begin n_err++; $display("FAIL post_reset_mfhi: got %b want 00", {md_busy, stall_if}); end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_md(1'b1);
    test_md(1'b0);
    test_mem_wait();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
